// File: rtl/tx_flow_gate.sv
// Transmit flow-control gate: buffers packed bytes in a FIFO and releases them
// to the UART only while the peer's synchronized clear-to-send is high.
// Also counts accepted bytes and pulses frame_done_o at the end of each frame.
module tx_flow_gate #(
  parameter int unsigned width_p       = 8,
  parameter int unsigned depth_p       = 16,
  parameter int unsigned frame_bytes_p = 9600
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [width_p-1:0]           data_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [width_p-1:0]           data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  input  logic                         cts_i,
  output logic [$clog2(depth_p+1)-1:0] level_o,
  output logic                         frame_done_o
);

  localparam int unsigned AW = $clog2(depth_p);
  localparam int unsigned LW = $clog2(depth_p + 1);
  localparam int unsigned CW = $clog2(frame_bytes_p + 1);

  localparam logic [LW-1:0] FullLevel = LW'(depth_p);
  localparam logic [CW-1:0] FrameLast = CW'(frame_bytes_p - 1);

  localparam logic [0:0] StIdle    = 1'b0;
  localparam logic [0:0] StPresent = 1'b1;

  logic               cts_meta_q, cts_s_q;
  logic [width_p-1:0] mem_q [depth_p];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      count_q, count_d;
  logic [0:0]         state_q, state_d;
  logic [width_p-1:0] data_q, data_d;
  logic [CW-1:0]      frame_cnt_q, frame_cnt_d;
  logic               done_q, done_d;

  logic fifo_empty, fifo_full, wr_en, load, accept;

  // Two-flop synchronizer for the asynchronous clear-to-send input.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cts_meta_q <= 1'b0;
      cts_s_q    <= 1'b0;
    end else begin
      cts_meta_q <= cts_i;
      cts_s_q    <= cts_meta_q;
    end
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Handshakes, FIFO bookkeeping, output FSM and frame counter next-state.
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FullLevel);
    wr_en      = valid_i & ~fifo_full;
    accept     = (state_q == StPresent) & ready_i;
    // CTS gates only the start of a byte; a presented byte is always held.
    load       = ~fifo_empty & cts_s_q & ((state_q == StIdle) | ready_i);

    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = load  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    if (wr_en && !load) begin
      count_d = count_q + 1'b1;
    end else if (!wr_en && load) begin
      count_d = count_q - 1'b1;
    end

    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = StPresent;
      data_d  = mem_q[rd_ptr_q];
    end else if (accept) begin
      state_d = StIdle;
    end

    frame_cnt_d = frame_cnt_q;
    done_d      = 1'b0;
    if (accept) begin
      if (frame_cnt_q == FrameLast) begin
        frame_cnt_d = '0;
        done_d      = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // State registers; reset discards FIFO, presented byte and frame count.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= StIdle;
      data_q      <= '0;
      frame_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      data_q      <= data_d;
      frame_cnt_q <= frame_cnt_d;
      done_q      <= done_d;
    end
  end

  // Outputs are all taken directly from registers.
  always_comb begin
    ready_o      = ~fifo_full;
    valid_o      = (state_q == StPresent);
    data_o       = data_q;
    level_o      = count_q;
    frame_done_o = done_q;
  end

endmodule

// File: tb/tb_tx_flow_gate.sv
// Self-checking bench for tx_flow_gate: scoreboard of written bytes, popped
// and compared on each downstream accept.
module tb_tx_flow_gate;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 16;
  localparam int unsigned F  = 4;
  localparam int unsigned LW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          reset_i;
  logic [W-1:0]  data_i;
  logic          valid_i;
  logic          ready_o;
  logic [W-1:0]  data_o;
  logic          valid_o;
  logic          ready_i;
  logic          cts_i;
  logic [LW-1:0] level_o;
  logic          frame_done_o;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb [$];

  tx_flow_gate #(
    .width_p      (W),
    .depth_p      (D),
    .frame_bytes_p(F)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .cts_i       (cts_i),
    .level_o     (level_o),
    .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  // Advance one full cycle, ending on the falling edge where sampling occurs.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Record the handshakes that the next rising edge will perform; push writes,
  // pop the expected byte for an accept.
  task automatic observe(output bit wr, output bit acc, output bit have,
                         output logic [W-1:0] exp);
    wr   = valid_i & ready_o;
    acc  = valid_o & ready_i;
    have = 1'b0;
    exp  = '0;
    if (acc && sb.size() > 0) begin
      have = 1'b1;
      exp  = sb.pop_front();
    end
    if (wr) sb.push_back(data_i);
  endtask

  task automatic test_reset();
    bit wr, acc, have;
    logic [W-1:0] exp;
    #12;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", valid_o); end
    checks++; if (data_o !== '0) begin errors++; $display("FAIL rst_data got %h want 00", data_o); end
    checks++; if (level_o !== '0) begin errors++; $display("FAIL rst_level got %0d want 0", level_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", ready_o); end
    checks++; if (frame_done_o !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", frame_done_o); end
    @(negedge clk);
    reset_i = 1'b0;
    cts_i   = 1'b1;
    ready_i = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1;
      data_i  = 8'(8'hA0 + i);
      observe(wr, acc, have, exp);
      tick();
    end
    valid_i = 1'b0;
    repeat (2) tick();
    checks++; if (valid_o !== 1'b1 || data_o !== 8'hA0) begin
      errors++; $display("FAIL pre_rst_present got v=%b d=%h want v=1 d=a0", valid_o, data_o);
    end
    // Asynchronous assertion in the middle of the high phase.
    @(posedge clk);
    #2 reset_i = 1'b1;
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL async_rst_valid got %b want 0", valid_o); end
    checks++; if (data_o !== '0) begin errors++; $display("FAIL async_rst_data got %h want 00", data_o); end
    checks++; if (level_o !== '0) begin errors++; $display("FAIL async_rst_level got %0d want 0", level_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL async_rst_ready got %b want 1", ready_o); end
    @(negedge clk);
    reset_i = 1'b0;
    sb.delete();
  endtask

  task automatic test_pass_through();
    bit wr, acc, have;
    logic [W-1:0] exp;
    int sent = 0, got = 0, first = -1, last = -1;
    cts_i   = 1'b1;
    ready_i = 1'b1;
    valid_i = 1'b0;
    repeat (3) tick();
    for (int cyc = 0; cyc < 80 && got < 32; cyc++) begin
      valid_i = (sent < 32);
      data_i  = 8'(sent + 1);
      observe(wr, acc, have, exp);
      if (valid_o && first < 0) first = cyc;
      if (acc) begin
        checks++;
        if (!have || data_o !== exp) begin
          errors++; $display("FAIL pass_data got %h want %h (have=%b)", data_o, exp, have);
        end
        got++;
        last = cyc;
      end
      if (wr) sent++;
      tick();
    end
    valid_i = 1'b0;
    checks++; if (first != 2) begin errors++; $display("FAIL pass_latency got %0d want 2", first); end
    checks++; if (last != 33) begin errors++; $display("FAIL pass_rate last accept cycle %0d want 33", last); end
    checks++; if (got != 32) begin errors++; $display("FAIL pass_count got %0d want 32", got); end
  endtask

  task automatic test_cts_stall();
    bit wr, acc, have;
    logic [W-1:0] exp;
    int first = -1, got = 0;
    cts_i   = 1'b0;
    ready_i = 1'b1;
    valid_i = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 16; i++) begin
      valid_i = 1'b1;
      data_i  = 8'(8'h40 + i);
      observe(wr, acc, have, exp);
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL stall_valid got %b want 0", valid_o); end
      tick();
    end
    valid_i = 1'b0;
    checks++; if (level_o !== 5'(16)) begin errors++; $display("FAIL stall_level got %0d want 16", level_o); end
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready got %b want 0", ready_o); end
    // Offer a byte while full; it must not enter.
    valid_i = 1'b1;
    data_i  = 8'hEE;
    observe(wr, acc, have, exp);
    tick();
    valid_i = 1'b0;
    checks++; if (level_o !== 5'(16) || valid_o !== 1'b0) begin
      errors++; $display("FAIL full_offer got level=%0d v=%b want 16 0", level_o, valid_o);
    end
    cts_i = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 16; cyc++) begin
      observe(wr, acc, have, exp);
      if (valid_o && first < 0) first = cyc;
      if (acc) begin
        checks++;
        if (!have || data_o !== exp) begin
          errors++; $display("FAIL stall_data got %h want %h (have=%b)", data_o, exp, have);
        end
        got++;
      end
      tick();
    end
    checks++; if (first != 3) begin errors++; $display("FAIL cts_latency got %0d want 3", first); end
    checks++; if (got != 16) begin errors++; $display("FAIL stall_count got %0d want 16", got); end
  endtask

  task automatic test_cts_drop();
    bit wr, acc, have;
    logic [W-1:0] exp, held;
    int n1 = 0, n2 = 0;
    cts_i   = 1'b1;
    ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      valid_i = 1'b1;
      data_i  = 8'(8'h80 + i);
      observe(wr, acc, have, exp);
      tick();
    end
    valid_i = 1'b0;
    held  = data_o;
    cts_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      observe(wr, acc, have, exp);
      checks++;
      if (valid_o !== 1'b1 || data_o !== held) begin
        errors++; $display("FAIL drop_hold got v=%b d=%h want v=1 d=%h", valid_o, data_o, held);
      end
      tick();
    end
    ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      observe(wr, acc, have, exp);
      if (!valid_o) break;
      checks++;
      if (!have || data_o !== exp) begin
        errors++; $display("FAIL drop1_data got %h want %h", data_o, exp);
      end
      n1++;
      tick();
    end
    checks++; if (n1 != 1 || valid_o !== 1'b0) begin
      errors++; $display("FAIL drop1_count got %0d v=%b want 1 v=0", n1, valid_o);
    end
    ready_i = 1'b0;
    cts_i   = 1'b1;
    repeat (4) tick();
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL drop2_restart got %b want 1", valid_o); end
    cts_i   = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      observe(wr, acc, have, exp);
      if (!valid_o) break;
      checks++;
      if (!have || data_o !== exp) begin
        errors++; $display("FAIL drop2_data got %h want %h", data_o, exp);
      end
      n2++;
      tick();
    end
    checks++; if (n2 < 1 || n2 > 3 || valid_o !== 1'b0) begin
      errors++; $display("FAIL drop2_count got %0d v=%b want 1..3 v=0", n2, valid_o);
    end
    checks++; if (int'(level_o) + n1 + n2 != 8) begin
      errors++; $display("FAIL drop_conserve got %0d want 8", int'(level_o) + n1 + n2);
    end
    cts_i = 1'b1;
    for (int i = 0; i < 40 && (sb.size() > 0 || valid_o); i++) begin
      observe(wr, acc, have, exp);
      if (acc) begin
        checks++;
        if (!have || data_o !== exp) begin
          errors++; $display("FAIL drop_drain got %h want %h", data_o, exp);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    bit wr, acc, have;
    logic [W-1:0] exp, prev_data = '0;
    bit prev_stall = 1'b0;
    cts_i = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (prev_stall) begin
        checks++;
        if (valid_o !== 1'b1 || data_o !== prev_data) begin
          errors++; $display("FAIL b2b_hold got v=%b d=%h want v=1 d=%h", valid_o, data_o, prev_data);
        end
      end
      valid_i = 1'($urandom_range(0, 1));
      data_i  = 8'($urandom);
      ready_i = 1'($urandom_range(0, 1));
      observe(wr, acc, have, exp);
      if (acc) begin
        checks++;
        if (!have || data_o !== exp) begin
          errors++; $display("FAIL b2b_data got %h want %h (have=%b)", data_o, exp, have);
        end
      end
      prev_stall = valid_o & ~ready_i;
      prev_data  = data_o;
      tick();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 60 && (sb.size() > 0 || valid_o); i++) begin
      observe(wr, acc, have, exp);
      if (acc) begin
        checks++;
        if (!have || data_o !== exp) begin
          errors++; $display("FAIL b2b_drain got %h want %h (have=%b)", data_o, exp, have);
        end
      end
      tick();
    end
    checks++; if (sb.size() != 0 || valid_o !== 1'b0) begin
      errors++; $display("FAIL b2b_left got %0d pending v=%b want 0 v=0", sb.size(), valid_o);
    end
    checks++; if (level_o !== '0) begin errors++; $display("FAIL b2b_level got %0d want 0", level_o); end
  endtask

  task automatic test_frame();
    bit wr, acc, have;
    logic [W-1:0] exp;
    int sent = 0, got = 0, extra = 0, fcnt = 0, pulses = 0;
    bit done_exp = 1'b0;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    sb.delete();
    cts_i   = 1'b1;
    ready_i = 1'b1;
    valid_i = 1'b0;
    repeat (3) tick();
    for (int cyc = 0; cyc < 60 && extra < 3; cyc++) begin
      valid_i = (sent < 10);
      data_i  = 8'(8'hC0 + sent);
      observe(wr, acc, have, exp);
      checks++;
      if (frame_done_o !== done_exp) begin
        errors++; $display("FAIL frame_done cyc %0d got %b want %b", cyc, frame_done_o, done_exp);
      end
      if (frame_done_o === 1'b1) pulses++;
      done_exp = 1'b0;
      if (acc) begin
        checks++;
        if (!have || data_o !== exp) begin
          errors++; $display("FAIL frame_data got %h want %h", data_o, exp);
        end
        got++;
        fcnt++;
        if (fcnt == int'(F)) begin
          fcnt     = 0;
          done_exp = 1'b1;
        end
      end
      if (wr) sent++;
      if (got == 10) extra++;
      tick();
    end
    checks++; if (pulses != 2) begin errors++; $display("FAIL frame_pulses got %0d want 2", pulses); end
    checks++; if (int'(dut.frame_cnt_q) != 2) begin
      errors++; $display("FAIL frame_count got %0d want 2", int'(dut.frame_cnt_q));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset_i = 1'b1;
    valid_i = 1'b0;
    data_i  = '0;
    ready_i = 1'b0;
    cts_i   = 1'b0;
    test_reset();
    test_pass_through();
    test_cts_stall();
    test_cts_drop();
    test_back_to_back();
    test_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_flow_gate.md
# tx_flow_gate

Transmit-side flow-control gate between the output packer and the UART transmitter. It buffers packed bytes and releases them to the UART only while the downstream receiver (the ESP) asserts clear-to-send. This mirrors the receive path, where the skid buffer drives `uart_rts_o` to throttle the sender. It also counts transmitted bytes and flags the end of each image frame.

## Interface
Parameters:
- `width_p`, 8: byte width on both AXIS sides.
- `depth_p`, 16: FIFO entries; must be a power of two, ≥ 2.
- `frame_bytes_p`, 9600: bytes per frame (320×240 / 8); ≥ 1.

Ports:
- `clk_i`  in  1  single clock, 25 MHz.
- `reset_i`  in  1  asynchronous, active-high reset.
- `data_i`  in  `width_p`  packed byte from the packer.
- `valid_i`  in  1  upstream valid.
- `ready_o`  out  1  upstream ready; equals `!full`.
- `data_o`  out  `width_p`  byte to the UART `s_axis_tdata`.
- `valid_o`  out  1  downstream valid.
- `ready_i`  in  1  UART `s_axis_tready`.
- `cts_i`  in  1  clear-to-send from the peer; asynchronous; high means the peer may receive.
- `level_o`  out  `$clog2(depth_p+1)`  current FIFO occupancy, excluding the output register.
- `frame_done_o`  out  1  one-cycle pulse after the last byte of a frame is accepted downstream.

## Operation
- `cts_i` passes through a 2-flop synchronizer to produce `cts_s`. Only `cts_s` is used internally.
- FIFO:
  - A write occurs on `valid_i & ready_o`.
  - A read occurs when the output stage loads.
  - Read and write in the same cycle are allowed at any occupancy below full. When full, `ready_o` is 0, so no write can occur.
- Output stage is a registered byte plus a two-state FSM:
  - **IDLE** (`valid_o` = 0). Go to PRESENT when FIFO is non-empty and `cts_s` = 1; load `data_o` from the FIFO head (this is the read).
  - **PRESENT** (`valid_o` = 1, `data_o` stable). On `ready_i`:
    - if FIFO is non-empty and `cts_s` = 1: load the next byte and stay in PRESENT (back-to-back, no bubble);
    - otherwise: go to IDLE.
  - While in PRESENT, `cts_s` falling never drops `valid_o`; the AXIS hold rule has priority. CTS gates only the start of a new byte.
- Frame counter: increments on each `valid_o & ready_i`. On the accept that makes the count `frame_bytes_p`, the counter wraps to 0 and `frame_done_o` pulses high for the following cycle.
- `level_o` is the registered FIFO count.

## Timing
- Reset values:
  - `valid_o` = 0, `data_o` = 0, `frame_done_o` = 0, `level_o` = 0.
  - `ready_o` = 1 (FIFO empty).
  - FSM in IDLE, frame counter = 0, both sync flops = 0, so CTS is deasserted after reset.
- Reset asserted mid-operation: the FIFO, the output register and the frame count are discarded immediately (asynchronous). Any byte presented is lost; `valid_o` falls without a handshake.
- Latency with FIFO empty and `cts_s` = 1: a byte written at edge N is presented with `valid_o` = 1 after edge N+1.
- Throughput: one byte per cycle when `ready_i` and `cts_s` are held high.
- CTS latency: a change on `cts_i` affects loading 2 edges later.
  - After `cts_i` falls, at most 2 further bytes may start, plus the byte already in PRESENT.
  - The peer's headroom must be ≥ 3 bytes.
- Full: `ready_o` = 0 exactly when `level_o` = `depth_p`. It returns to 1 the cycle after a read.
- Empty with `cts_s` = 1: FSM stays in IDLE, with no spurious `valid_o`.
- `frame_done_o` is independent of CTS and back-pressure. Frames are back-to-back, with no idle byte inserted.

## Test plan
- **Reset:** assert `reset_i` asynchronously mid-cycle → all outputs immediately at reset values; `ready_o` = 1, `level_o` = 0.
- **Pass-through:** hold `cts_i` = 1 and `ready_i` = 1; send 0x01..0x20 → identical sequence on `data_o`, first `valid_o` 2 edges after the first write, then one byte per cycle.
- **CTS stall:**
  - With `cts_i` = 0, write 16 bytes → `level_o` = 16, `ready_o` = 0, `valid_o` = 0 throughout.
  - Raise `cts_i` → first `valid_o` 3 edges later; all 16 bytes out in order.
- **CTS drop during stream:** drop `cts_i` while `valid_o` = 1 and `ready_i` = 0 → `valid_o` and `data_o` held until `ready_i`; then at most 2 more bytes start before `valid_o` falls.
- **Back-pressure plus simultaneous read/write:** random `ready_i` at 50% and random `valid_i` → scoreboard shows no loss, duplication or reordering; `data_o` never changes while `valid_o & !ready_i`.
- **Frame marker:** with `frame_bytes_p` = 4, send 10 bytes → `frame_done_o` pulses the cycle after the 4th and 8th accepts only; the counter holds 2 at the end.
